// File: rtl/ucounter8.sv
// ucounter8: 8-bit up/down counter with a preload, a wrap-or-stop terminal mode and an
// overflow flag.
// The counter has an asynchronous active-high reset (_areset) and an asynchronous
// active-low set (_aset). It also has a synchronous active-low load (_load).
// Optional feature: define UCOUNTER8_STICKY_OVF_EN to make overflow sticky. Once set, it
// then holds until _areset, _aset or a load clears it. Without the macro, overflow is
// high only on edges that produced a terminal event.
module ucounter8 (
  output logic       overflow,
  output logic [7:0] dcount,
  input  logic       clk,
  input  logic       _areset,
  input  logic       _aset,
  input  logic       _load,
  input  logic [7:0] preld_val,
  input  logic       _updown,
  input  logic       _wrapstop
);

  logic [7:0] r_dcount;
  logic       r_overflow;
  logic [7:0] w_next_count;
  logic       w_next_ovf;
  logic       w_terminal;

  // Terminal value depends on the direction sampled this edge: FF going up, 00 going down.
  always_comb begin
    w_terminal = 1'b0;
    if (_updown) begin
      w_terminal = (r_dcount == 8'hFF);
    end else begin
      w_terminal = (r_dcount == 8'h00);
    end
  end

  // Next-state selection: a load beats counting; a step from the terminal value wraps or holds.
  always_comb begin
    w_next_count = r_dcount;
    w_next_ovf   = 1'b0;
    if (!_load) begin
      // Loading a terminal value does not flag; the next counting edge evaluates it.
      w_next_count = preld_val;
      w_next_ovf   = 1'b0;
    end else if (w_terminal) begin
      w_next_ovf = 1'b1;
      if (_wrapstop) begin
        w_next_count = _updown ? 8'h00 : 8'hFF;
      end
    end else begin
      w_next_count = _updown ? (r_dcount + 8'd1) : (r_dcount - 8'd1);
`ifdef UCOUNTER8_STICKY_OVF_EN
      w_next_ovf = r_overflow;
`else
      w_next_ovf = 1'b0;
`endif
    end
  end

  // State register: the async reset beats the async set, and both beat the clocked update.
  always_ff @(posedge clk or posedge _areset or negedge _aset) begin
    if (_areset) begin
      r_dcount   <= 8'h00;
      r_overflow <= 1'b0;
    end else if (!_aset) begin
      r_dcount   <= 8'hFF;
      r_overflow <= 1'b0;
    end else begin
      r_dcount   <= w_next_count;
      r_overflow <= w_next_ovf;
    end
  end

  assign dcount   = r_dcount;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ucounter8.sv
// tb_ucounter8: self-checking bench for ucounter8.
// The bench keeps an integer-arithmetic reference model and compares the DUT against it
// on every falling clock edge. It also runs a set of directed cases with literal
// expectations, including the sticky-overflow case when UCOUNTER8_STICKY_OVF_EN is defined.
module tb_ucounter8;

  logic       clk;
  logic       areset;
  logic       aset;
  logic       load;
  logic [7:0] preld;
  logic       updown;
  logic       wrapstop;
  logic       overflow;
  logic [7:0] dcount;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  // Reference model state: count kept as a plain integer, flag as a bit.
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  ucounter8 dut (
    .overflow  (overflow),
    .dcount    (dcount),
    .clk       (clk),
    ._areset   (areset),
    ._aset     (aset),
    ._load     (load),
    .preld_val (preld),
    ._updown   (updown),
    ._wrapstop (wrapstop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cnt();
    if (areset) return 8'h00;
    if (!aset) return 8'hFF;
    return 8'(m_cnt);
  endfunction

  function automatic logic exp_ovf();
    if (areset || !aset) return 1'b0;
    return m_ovf;
  endfunction

  // Model: a step outside 0..255 is a terminal event; wrap takes it modulo 256, stop holds.
  always @(posedge clk) begin
    int nxt;
    if (areset) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (!aset) begin
      m_cnt = 255;
      m_ovf = 1'b0;
    end else if (!load) begin
      m_cnt = int'(preld);
      m_ovf = 1'b0;
    end else begin
      nxt = updown ? m_cnt + 1 : m_cnt - 1;
      if (nxt < 0 || nxt > 255) begin
        m_ovf = 1'b1;
        if (wrapstop) m_cnt = (nxt + 256) % 256;
      end else begin
        m_cnt = nxt;
`ifndef UCOUNTER8_STICKY_OVF_EN
        m_ovf = 1'b0;
`endif
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!done) begin
      chk("cyc_dcount", {1'b0, dcount}, {1'b0, exp_cnt()});
      chk("cyc_overflow", {8'h00, overflow}, {8'h00, exp_ovf()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the async controls. The model takes the forced value at once; the DUT is checked
  // without any clock edge.
  task automatic set_async(input logic ar, input logic as_n);
    areset = ar;
    aset   = as_n;
    if (ar) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (!as_n) begin
      m_cnt = 255;
      m_ovf = 1'b0;
    end
    #1;
    chk("async_dcount", {1'b0, dcount}, {1'b0, exp_cnt()});
    chk("async_overflow", {8'h00, overflow}, {8'h00, exp_ovf()});
  endtask

  task automatic lit(input string nm, input logic [7:0] c, input logic o);
    chk({nm, "_dcount"}, {1'b0, dcount}, {1'b0, c});
    chk({nm, "_overflow"}, {8'h00, overflow}, {8'h00, o});
  endtask

  initial begin
    load     = 1'b1;
    preld    = 8'h00;
    updown   = 1'b1;
    wrapstop = 1'b1;
    aset     = 1'b1;
    areset   = 1'b1;
    m_cnt    = 0;
    m_ovf    = 1'b0;
    #2;
    lit("reset", 8'h00, 1'b0);

    // Count up from reset.
    tick();
    set_async(1'b0, 1'b1);
    lit("up0", 8'h00, 1'b0);
    tick(); lit("up1", 8'h01, 1'b0);
    tick(); lit("up2", 8'h02, 1'b0);
    tick(); lit("up3", 8'h03, 1'b0);

    // Load FE, then count up in wrap mode through FF to 00.
    load = 1'b0; preld = 8'hFE;
    tick(); lit("ldFE", 8'hFE, 1'b0);
    load = 1'b1;
    tick(); lit("wrapFF", 8'hFF, 1'b0);
    tick(); lit("wrap00", 8'h00, 1'b1);
`ifdef UCOUNTER8_STICKY_OVF_EN
    tick(); lit("wrap01", 8'h01, 1'b1);
`else
    tick(); lit("wrap01", 8'h01, 1'b0);
`endif

    // Load 01, then count down in stop mode and hold at 00.
    load = 1'b0; preld = 8'h01; updown = 1'b0; wrapstop = 1'b0;
    tick(); lit("ld01", 8'h01, 1'b0);
    load = 1'b1;
    tick(); lit("stop_a", 8'h00, 1'b0);
    tick(); lit("stop_b", 8'h00, 1'b1);
    tick(); lit("stop_c", 8'h00, 1'b1);

    // A load during a terminal event takes the preload value and clears overflow.
    load = 1'b0; preld = 8'h80;
    tick(); lit("ld80", 8'h80, 1'b0);

    // Async set mid-count, then async reset while the set is still active.
    preld = 8'h5A; updown = 1'b1; wrapstop = 1'b1;
    tick(); lit("ld5A", 8'h5A, 1'b0);
    load = 1'b1;
    tick(); lit("cnt5B", 8'h5B, 1'b0);
    set_async(1'b0, 1'b0); lit("aset", 8'hFF, 1'b0);
    set_async(1'b1, 1'b0); lit("both", 8'h00, 1'b0);
    tick(); lit("both_hold", 8'h00, 1'b0);
    set_async(1'b0, 1'b1);
    tick(); lit("resume", 8'h01, 1'b0);

    // Stop mode going up: hold at FF with overflow high.
    load = 1'b0; preld = 8'hFF; wrapstop = 1'b0;
    tick(); lit("ldFF", 8'hFF, 1'b0);
    load = 1'b1;
    tick(); lit("stopup_a", 8'hFF, 1'b1);
    tick(); lit("stopup_b", 8'hFF, 1'b1);
    updown = 1'b0;
    tick(); lit("turn", 8'hFE, 1'b0 | m_ovf);

`ifdef UCOUNTER8_STICKY_OVF_EN
    // Sticky overflow: set by the wrap, held for 5 counts, then cleared by a load.
    load = 1'b0; preld = 8'hFF; updown = 1'b1; wrapstop = 1'b1;
    tick(); lit("s_ld", 8'hFF, 1'b0);
    load = 1'b1;
    tick(); lit("s_wrap", 8'h00, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick(); lit("s_hold", 8'(k), 1'b1);
    end
    load = 1'b0; preld = 8'h10;
    tick(); lit("s_ldclr", 8'h10, 1'b0);
    load = 1'b1; preld = 8'hFF;
    load = 1'b0;
    tick();
    load = 1'b1;
    tick(); lit("s_wrap2", 8'h00, 1'b1);
    tick(); lit("s_hold2", 8'h01, 1'b1);
    set_async(1'b1, 1'b1); lit("s_rstclr", 8'h00, 1'b0);
    set_async(1'b0, 1'b1);
`endif

    // Randomized phase, checked by the every-cycle compare against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      set_async(1'($urandom_range(63) == 0), 1'($urandom_range(63) != 0));
      load     = 1'($urandom_range(7) != 0);
      preld    = 8'($urandom);
      updown   = 1'($urandom_range(1));
      wrapstop = 1'($urandom_range(3) != 0);
    end

    tick();
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ucounter8.md
UCOUNTER8 -- requirements
Module: ucounter8

Interface
REQ-001 clk  input  1  sole clock; all synchronous updates on rising edge.
REQ-002 _areset  input  1  asynchronous reset, active-high despite the underscore prefix; clears counter and overflow.
REQ-003 _aset  input  1  asynchronous set, active-low; forces counter to all-ones.
REQ-004 _load  input  1  synchronous load, active-low; loads preld_val.
REQ-005 preld_val  input  8  preload value, sampled only on a load edge.
REQ-006 _updown  input  1  direction: 1 = count up, 0 = count down.
REQ-007 _wrapstop  input  1  terminal behaviour: 1 = wrap-around, 0 = stop (saturate) at terminal value.
REQ-008 dcount  output  8  registered counter value, unsigned.
REQ-009 overflow  output  1  registered terminal-event flag.
REQ-010 Port order SHALL be: overflow, dcount, clk, _areset, _aset, _load, preld_val, _updown, _wrapstop.

Function
REQ-011 Priority SHALL be: _areset, then _aset, then _load, then counting.
REQ-012 With no reset, set or load active, dcount SHALL change by exactly 1 per rising clk edge; there is no separate count enable.
REQ-013 Up count: dcount SHALL become dcount+1, modulo 256.
REQ-014 Down count: dcount SHALL become dcount-1, modulo 256.
REQ-015 Terminal value SHALL be 8'hFF when counting up and 8'h00 when counting down.
REQ-016 Wrap mode (_wrapstop=1), counter at terminal: dcount SHALL wrap (FF->00 up, 00->FF down), and overflow SHALL be 1 on the same edge.
REQ-017 Stop mode (_wrapstop=0), counter at terminal: dcount SHALL hold, and overflow SHALL be 1 on that edge (a blocked step).
REQ-018 On any edge without a terminal event, overflow SHALL be 0, except as modified by REQ-027.
REQ-019 Load edge (_load=0): dcount SHALL be preld_val and overflow SHALL be 0, regardless of direction or mode.
REQ-020 _updown and _wrapstop SHALL be sampled per edge; changing them mid-count takes effect on the next edge with no extra latency.
REQ-021 Loading the terminal value SHALL NOT by itself set overflow; the following counting edge evaluates REQ-016/017.

Reset
REQ-022 _areset=1 SHALL immediately, without waiting for clk, force dcount=8'h00 and overflow=0, and hold them while asserted.
REQ-023 _aset=0 with _areset=0 SHALL immediately force dcount=8'hFF and overflow=0, and hold them while asserted.
REQ-024 If _areset and _aset are active together, reset SHALL win: dcount=00.
REQ-025 After either asynchronous control is released, counting SHALL resume on the first subsequent rising clk edge.
REQ-026 An asynchronous reset asserted mid-count SHALL abort the count with no residual overflow.

Configuration
REQ-027 Macro UCOUNTER8_STICKY_OVF_EN:
- Defined: overflow is sticky. Once set, it stays 1 until _areset, _aset or a load clears it.
- Undefined: overflow follows REQ-016..018, i.e. it is high only for edges that produced a terminal event. In stop mode it therefore stays high while counting continues to be blocked at the terminal value.

Verification
REQ-028 _areset=1 pulse; then _areset=0, _aset=1, _load=1, _updown=1, _wrapstop=1; 3 clks -> dcount 00,01,02,03; overflow 0 throughout.
REQ-029 Load preld_val=8'hFE, up, wrap; 2 clks -> dcount FF with overflow 0, then 00 with overflow 1; next clk -> 01 with overflow 0 (macro undefined).
REQ-030 Load 8'h01, down, stop; 3 clks -> dcount 00, 00, 00; overflow 0, 1, 1.
REQ-031 Counting at 8'h5A, assert _aset=0 between edges -> dcount FF immediately; then assert _areset=1 with _aset still 0 -> dcount 00 immediately.
REQ-032 _load=0 with preld_val=8'h80 while the counter is in a terminal event -> dcount 80, overflow 0 on that edge.
REQ-033 Macro defined: wrap FF->00 sets overflow; it stays 1 through 5 further counts and clears on _load=0 or _areset=1.
